// File: rtl/rom_loader.sv
// Boot loader: copies a ROM image from SPI flash (mode 0, READ 0x03, one continuous burst)
// into the on-chip ROM array. Holds the system in reset via busy until the copy completes.
module rom_loader #(
    parameter int          KB         = 128,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CLKDIV     = 2,
    localparam int         AW         = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          spi_cs_n,
    output logic          spi_sck,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_d,
    output logic          mem_w,
    output logic          busy,
    output logic          done
);

    localparam int          NBYTES    = KB * 1024;
    localparam int          PW        = (2 * CLKDIV > 2) ? $clog2(2 * CLKDIV) : 1;
    localparam logic [PW-1:0] P_HALF   = PW'(CLKDIV);
    localparam logic [PW-1:0] P_SAMPLE = PW'(CLKDIV - 1);
    localparam logic [PW-1:0] P_END    = PW'(2 * CLKDIV - 1);
    localparam logic [31:0] CMD_WORD  = {8'h03, FLASH_BASE};
    localparam logic [AW:0] LAST_BYTE = (AW + 1)'(NBYTES - 1);

    typedef enum logic [1:0] {
        DESEL = 2'd0,
        CMD   = 2'd1,
        DATA  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] phase_r, phase_s, phase_inc_s;
    logic [4:0]    bit_r, bit_s;
    logic [AW:0]   byte_r, byte_s;
    logic [7:0]    shreg_r, shreg_s;
    logic          cs_n_s, sck_s, mosi_s, mem_w_s, busy_s, done_s;
    logic [AW-1:0] mem_a_s;
    logic [7:0]    mem_d_s;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        phase_inc_s = (phase_r == P_END) ? '0 : phase_r + PW'(1);
        state_s     = state_r;
        phase_s     = phase_inc_s;
        bit_s       = bit_r;
        byte_s      = byte_r;
        shreg_s     = shreg_r;
        cs_n_s      = 1'b0;
        sck_s       = 1'b0;
        mosi_s      = spi_mosi;
        mem_a_s     = mem_a;
        mem_d_s     = mem_d;
        mem_w_s     = 1'b0;
        busy_s      = 1'b1;
        done_s      = 1'b0;
        case (state_r)
            DESEL: begin
                if (phase_r == P_END) begin
                    state_s = CMD;
                    bit_s   = 5'd0;
                    mosi_s  = CMD_WORD[31];
                end else begin
                    cs_n_s  = 1'b1;
                end
            end
            CMD: begin
                sck_s = (phase_inc_s >= P_HALF);
                // MOSI only moves at the start of a bit period, while SCK is low.
                if (phase_r == P_END) begin
                    if (bit_r == 5'd31) begin
                        state_s = DATA;
                        bit_s   = 5'd0;
                        mosi_s  = 1'b0;
                    end else begin
                        bit_s   = bit_r + 5'd1;
                        mosi_s  = CMD_WORD[5'd30 - bit_r];
                    end
                end else begin
                    mosi_s = spi_mosi;
                end
            end
            DATA: begin
                sck_s = (phase_inc_s >= P_HALF);
                // Sample on the same edge that drives SCK 0->1.
                if (phase_r == P_SAMPLE) begin
                    shreg_s = {shreg_r[6:0], spi_miso};
                end else begin
                    shreg_s = shreg_r;
                end
                if (phase_r == P_END) begin
                    if (bit_r == 5'd7) begin
                        bit_s   = 5'd0;
                        mem_w_s = 1'b1;
                        mem_a_s = byte_r[AW-1:0];
                        mem_d_s = shreg_r;
                        byte_s  = byte_r + (AW + 1)'(1);
                        if (byte_r == LAST_BYTE) begin
                            state_s = FIN;
                            cs_n_s  = 1'b1;
                            sck_s   = 1'b0;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        bit_s = bit_r + 5'd1;
                    end
                end else begin
                    bit_s = bit_r;
                end
            end
            FIN: begin
                phase_s = phase_r;
                cs_n_s  = 1'b1;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end
            default: begin
                state_s = DESEL;
                phase_s = '0;
                cs_n_s  = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= DESEL;
            phase_r  <= '0;
            bit_r    <= 5'd0;
            byte_r   <= '0;
            shreg_r  <= 8'h00;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            mem_a    <= '0;
            mem_d    <= 8'h00;
            mem_w    <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            phase_r  <= phase_s;
            bit_r    <= bit_s;
            byte_r   <= byte_s;
            shreg_r  <= shreg_s;
            spi_cs_n <= cs_n_s;
            spi_sck  <= sck_s;
            spi_mosi <= mosi_s;
            mem_a    <= mem_a_s;
            mem_d    <= mem_d_s;
            mem_w    <= mem_w_s;
            busy     <= busy_s;
            done     <= done_s;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: three 1 KiB loaders (CLKDIV 2, 1, 3) each read from a
// mode-0 flash model whose data byte n is n[7:0]^8'hA5, updated on SCK falling edges only.
module tb_rom_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n [3];
    logic       sck  [3];
    logic       mosi [3];
    logic       miso [3];
    logic       mem_w[3];
    logic       busy [3];
    logic       done [3];
    logic [9:0] mem_a[3];
    logic [7:0] mem_d[3];

    int cd[3] = '{2, 1, 3};
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hold_bad = 0;

    int          cs_fall[3], sck_rise[3], last_rise[3], cmd_bits[3], nwr[3], bad_wr[3];
    int          w_in_cmd[3], last_w[3], done_cyc[3], mosi_bad[3], period_bad[3];
    int          gap_bad[3], post_bad[3], busy_bad[3];
    logic [31:0] cmd_word[3];
    logic        fin_cs[3], fin_sck[3], prev_sck[3], prev_mosi[3];

    always #5 clock = ~clock;

    rom_loader #(.KB(1), .FLASH_BASE(24'h010000), .CLKDIV(2)) dut_a (
        .clock(clock), .reset(reset), .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .mem_a(mem_a[0]), .mem_d(mem_d[0]), .mem_w(mem_w[0]),
        .busy(busy[0]), .done(done[0]));

    rom_loader #(.KB(1), .FLASH_BASE(24'h010000), .CLKDIV(1)) dut_b (
        .clock(clock), .reset(reset), .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .mem_a(mem_a[1]), .mem_d(mem_d[1]), .mem_w(mem_w[1]),
        .busy(busy[1]), .done(done[1]));

    rom_loader #(.KB(1), .FLASH_BASE(24'h010000), .CLKDIV(3)) dut_c (
        .clock(clock), .reset(reset), .spi_cs_n(cs_n[2]), .spi_sck(sck[2]), .spi_mosi(mosi[2]),
        .spi_miso(miso[2]), .mem_a(mem_a[2]), .mem_d(mem_d[2]), .mem_w(mem_w[2]),
        .busy(busy[2]), .done(done[2]));

    function automatic logic exp_bit(input int k);
        logic [7:0] b;
        b = 8'(k / 8) ^ 8'hA5;
        return b[7 - (k % 8)];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : flash
        int nbits = 0;
        always @(posedge sck[g] or posedge cs_n[g]) begin
            if (cs_n[g]) nbits = 0;
            else         nbits = nbits + 1;
        end
        always @(negedge sck[g] or posedge cs_n[g]) begin
            if (cs_n[g] || nbits < 32) miso[g] = 1'b1;
            else                       miso[g] = exp_bit(nbits - 32);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_obs();
        for (int i = 0; i < 3; i++) begin
            cs_fall[i] = -1; sck_rise[i] = -1; last_rise[i] = 0; cmd_bits[i] = 0;
            nwr[i] = 0; bad_wr[i] = 0; w_in_cmd[i] = 0; last_w[i] = 0; done_cyc[i] = -1;
            mosi_bad[i] = 0; period_bad[i] = 0; gap_bad[i] = 0; post_bad[i] = 0;
            busy_bad[i] = 0; cmd_word[i] = 32'h0; fin_cs[i] = 1'b0; fin_sck[i] = 1'b1;
            prev_sck[i] = 1'b0; prev_mosi[i] = 1'b0;
        end
    endtask

    task automatic observe();
        for (int i = 0; i < 3; i++) begin
            if (cs_fall[i] < 0 && cs_n[i] === 1'b0) cs_fall[i] = cyc;
            if (sck[i] === 1'b1 && prev_sck[i] === 1'b0) begin
                if (sck_rise[i] < 0) sck_rise[i] = cyc;
                else if (cyc - last_rise[i] != 2 * cd[i]) period_bad[i]++;
                last_rise[i] = cyc;
                if (cs_n[i] === 1'b0 && cmd_bits[i] < 32) begin
                    cmd_word[i] = {cmd_word[i][30:0], mosi[i]};
                    cmd_bits[i]++;
                end
            end
            if (sck[i] === 1'b1 && mosi[i] !== prev_mosi[i]) mosi_bad[i]++;
            if (mem_w[i] === 1'b1) begin
                if (cmd_bits[i] < 32) w_in_cmd[i]++;
                if (done_cyc[i] >= 0) post_bad[i]++;
                if (mem_a[i] !== 10'(nwr[i]) || mem_d[i] !== (8'(nwr[i]) ^ 8'hA5)) bad_wr[i]++;
                if (nwr[i] > 0 && cyc - last_w[i] < 16 * cd[i]) gap_bad[i]++;
                last_w[i] = cyc;
                nwr[i]++;
                if (nwr[i] == 1024) begin
                    fin_cs[i]  = cs_n[i];
                    fin_sck[i] = sck[i];
                end
            end
            if (done_cyc[i] < 0 && done[i] === 1'b1) done_cyc[i] = cyc;
            if (done_cyc[i] >= 0) begin
                if (busy[i] !== 1'b0 || done[i] !== 1'b1 || cs_n[i] !== 1'b1 || sck[i] !== 1'b0 ||
                    mem_a[i] !== 10'd1023 || mem_d[i] !== 8'h5A) post_bad[i]++;
            end else if (busy[i] !== 1'b1) begin
                busy_bad[i]++;
            end
            prev_sck[i]  = sck[i];
            prev_mosi[i] = mosi[i];
        end
    endtask

    function automatic bit settled();
        for (int i = 0; i < 3; i++)
            if (done_cyc[i] < 0 || cyc < done_cyc[i] + 1000) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clock);
        // reset held high for 50 cycles
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++)
                if (cs_n[i] !== 1'b1 || sck[i] !== 1'b0 || mem_w[i] !== 1'b0) hold_bad++;
        end
        check("reset_hold", 32'(hold_bad), 32'd0);
        check("rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("rst_sck", 32'(sck[0]), 32'd0);
        check("rst_mosi", 32'(mosi[0]), 32'd0);
        check("rst_mem_a", 32'(mem_a[0]), 32'd0);
        check("rst_mem_d", 32'(mem_d[0]), 32'd0);
        check("rst_mem_w", 32'(mem_w[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd1);
        check("rst_done", 32'(done[0]), 32'd0);

        // full load on all three loaders, then 1000+ idle cycles
        reset = 1'b0;
        reset_obs();
        cyc = 0;
        observe();
        while (!settled() && cyc < 60000) begin
            @(negedge clock);
            cyc++;
            observe();
        end
        check("load_timeout", 32'(settled()), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cs_fall_%0d", i), 32'(cs_fall[i]), 32'(2 * cd[i]));
            check($sformatf("sck_rise_%0d", i), 32'(sck_rise[i]), 32'(3 * cd[i]));
            check($sformatf("cmd_%0d", i), cmd_word[i], 32'h03010000);
            check($sformatf("nwrites_%0d", i), 32'(nwr[i]), 32'd1024);
            check($sformatf("wr_data_%0d", i), 32'(bad_wr[i]), 32'd0);
            check($sformatf("wr_in_cmd_%0d", i), 32'(w_in_cmd[i]), 32'd0);
            check($sformatf("bit_period_%0d", i), 32'(period_bad[i]), 32'd0);
            check($sformatf("mosi_stable_%0d", i), 32'(mosi_bad[i]), 32'd0);
            check($sformatf("wr_gap_%0d", i), 32'(gap_bad[i]), 32'd0);
            check($sformatf("last_w_min_%0d", i), 32'(last_w[i] >= 16449 * cd[i]), 32'd1);
            check($sformatf("last_w_max_%0d", i), 32'(last_w[i] <= 16452 * cd[i]), 32'd1);
            check($sformatf("fin_cs_%0d", i), 32'(fin_cs[i]), 32'd1);
            check($sformatf("fin_sck_%0d", i), 32'(fin_sck[i]), 32'd0);
            check($sformatf("done_cyc_%0d", i), 32'(done_cyc[i]), 32'(last_w[i] + 1));
            check($sformatf("busy_load_%0d", i), 32'(busy_bad[i]), 32'd0);
            check($sformatf("post_done_%0d", i), 32'(post_bad[i]), 32'd0);
        end

        // reset mid-load: run until byte 300 is written, then pulse reset once
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        reset_obs();
        cyc = 0;
        observe();
        while (nwr[0] < 301 && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            observe();
        end
        check("mid_reach", 32'(nwr[0]), 32'd301);
        check("mid_wr_data", 32'(bad_wr[0]), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_cs_n", 32'(cs_n[0]), 32'd1);
        check("mid_busy", 32'(busy[0]), 32'd1);
        check("mid_done", 32'(done[0]), 32'd0);
        check("mid_mem_w", 32'(mem_w[0]), 32'd0);
        reset_obs();
        cyc = 0;
        observe();
        while (nwr[0] < 1 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            observe();
        end
        check("re_cs_fall", 32'(cs_fall[0]), 32'd4);
        check("re_cmd", cmd_word[0], 32'h03010000);
        check("re_first_wr", 32'(nwr[0]), 32'd1);
        check("re_wr_addr0", 32'(bad_wr[0]), 32'd0);
        check("re_wr_in_cmd", 32'(w_in_cmd[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
